// File: rtl/dnoc_itf_in_d_channel_rx.sv
// rtl/dnoc_itf_in_d_channel_rx.sv - data-NoC receive channel: head decode, SRAM write address gen, return steering.
// Optional DNOC_RX_LEN_CHECK_EN: compare accepted flit count against the head length field for writes/drains.
module dnoc_itf_in_d_channel_rx #(
    parameter logic [3:0] NODE_ID = 4'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] out_flit,
    input  logic         out_last,
    input  logic         out_valid,
    output logic         out_ready,
    output logic [12:0]  mem_wr_addr,
    output logic [255:0] mem_wr_data,
    output logic         mem_wr_valid,
    input  logic         mem_wr_ready,
    output logic [255:0] core_rd_ret_data,
    output logic         core_rd_ret_valid,
    output logic         core_rd_ret_last,
    input  logic         core_rd_ret_ready,
    output logic [255:0] dma_wr_ret_data,
    output logic         dma_wr_ret_valid,
    output logic         dma_wr_ret_last,
    input  logic         dma_wr_ret_ready,
    output logic [3:0]   hdr_src_id,
    output logic         hdr_from_dma,
    output logic [11:0]  hdr_mc_scale,
    output logic         wr_done,
    output logic [1:0]   err,
    input  logic         err_clr
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_DRAIN, S_RET_CORE, S_RET_DMA} state_t;

    state_t      state_q, state_d;
    logic [12:0] len_l_q, len_l_d, stride_q, stride_d, gap_q, gap_d, total_n_q, total_n_d;
    logic [12:0] row_base_q, row_base_d, col_off_q, col_off_d;
    logic [12:0] inner_cnt_q, inner_cnt_d, beat_cnt_q, beat_cnt_d, addr_q, addr_d;
    logic [3:0]  src_q, src_d;
    logic        from_dma_q, from_dma_d;
    logic [11:0] mc_q, mc_d;
    logic        wr_done_q, wr_done_d;
    logic [1:0]  err_q, err_d;
    logic        len_bad;

    assign mem_wr_data      = out_flit;
    assign core_rd_ret_data = out_flit;
    assign dma_wr_ret_data  = out_flit;
    assign mem_wr_addr      = addr_q;
    assign hdr_src_id       = src_q;
    assign hdr_from_dma     = from_dma_q;
    assign hdr_mc_scale     = mc_q;
    assign wr_done          = wr_done_q;
    assign err              = err_q;

`ifdef DNOC_RX_LEN_CHECK_EN
    assign len_bad = (beat_cnt_q + 13'd1) != total_n_q;
    logic unused_flit_bits;
    assign unused_flit_bits = ^{out_flit[255:160], out_flit[146:108], out_flit[81:56], out_flit[42:31]};
`else
    assign len_bad = 1'b0;
    logic unused_flit_bits;
    assign unused_flit_bits = ^{out_flit[255:160], out_flit[146:108], out_flit[81:56], out_flit[42:31], total_n_q};
`endif

    always_comb begin
        state_d     = state_q;
        len_l_d     = len_l_q;
        stride_d    = stride_q;
        gap_d       = gap_q;
        total_n_d   = total_n_q;
        row_base_d  = row_base_q;
        col_off_d   = col_off_q;
        inner_cnt_d = inner_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        addr_d      = addr_q;
        src_d       = src_q;
        from_dma_d  = from_dma_q;
        mc_d        = mc_q;
        wr_done_d   = 1'b0;
        err_d       = err_clr ? 2'b00 : err_q;
        out_ready         = 1'b0;
        mem_wr_valid      = 1'b0;
        core_rd_ret_valid = 1'b0;
        core_rd_ret_last  = 1'b0;
        dma_wr_ret_valid  = 1'b0;
        dma_wr_ret_last   = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_ready = 1'b1;
                if (out_valid) begin
                    len_l_d     = out_flit[159:147];
                    stride_d    = out_flit[107:95];
                    gap_d       = out_flit[94:82];
                    total_n_d   = out_flit[55:43];
                    src_d       = out_flit[17:14];
                    from_dma_d  = out_flit[13];
                    mc_d        = out_flit[11:0];
                    row_base_d  = out_flit[30:18];
                    addr_d      = out_flit[30:18];
                    col_off_d   = '0;
                    inner_cnt_d = '0;
                    beat_cnt_d  = '0;
                    if (out_flit[12]) begin
                        if (!out_last) state_d = out_flit[13] ? S_RET_DMA : S_RET_CORE;
                    end else begin
                        if (out_flit[3:0] != NODE_ID) err_d[1] = 1'b1;
                        if (out_last) wr_done_d = 1'b1;
                        else state_d = (out_flit[3:0] == NODE_ID) ? S_WR : S_DRAIN;
                    end
                end
            end
            S_WR: begin
                out_ready    = mem_wr_ready;
                mem_wr_valid = out_valid;
                if (out_valid && mem_wr_ready) begin
                    beat_cnt_d = beat_cnt_q + 13'd1;
                    // L==0 disables the outer wrap; the column just keeps striding.
                    if (len_l_q != '0 && inner_cnt_q == len_l_q - 13'd1) begin
                        row_base_d  = row_base_q + gap_q;
                        col_off_d   = '0;
                        inner_cnt_d = '0;
                        addr_d      = row_base_q + gap_q;
                    end else begin
                        col_off_d   = col_off_q + stride_q;
                        inner_cnt_d = inner_cnt_q + 13'd1;
                        addr_d      = row_base_q + col_off_q + stride_q;
                    end
                    if (out_last) begin
                        wr_done_d = 1'b1;
                        state_d   = S_IDLE;
                        if (len_bad) err_d[0] = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                out_ready = 1'b1;
                if (out_valid) begin
                    beat_cnt_d = beat_cnt_q + 13'd1;
                    if (out_last) begin
                        state_d = S_IDLE;
                        if (len_bad) err_d[0] = 1'b1;
                    end
                end
            end
            S_RET_CORE: begin
                out_ready         = core_rd_ret_ready;
                core_rd_ret_valid = out_valid;
                core_rd_ret_last  = out_last;
                if (out_valid && core_rd_ret_ready) begin
                    beat_cnt_d = beat_cnt_q + 13'd1;
                    if (out_last) state_d = S_IDLE;
                end
            end
            S_RET_DMA: begin
                out_ready        = dma_wr_ret_ready;
                dma_wr_ret_valid = out_valid;
                dma_wr_ret_last  = out_last;
                if (out_valid && dma_wr_ret_ready) begin
                    beat_cnt_d = beat_cnt_q + 13'd1;
                    if (out_last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_l_q     <= '0;
            stride_q    <= '0;
            gap_q       <= '0;
            total_n_q   <= '0;
            row_base_q  <= '0;
            col_off_q   <= '0;
            inner_cnt_q <= '0;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            src_q       <= '0;
            from_dma_q  <= 1'b0;
            mc_q        <= '0;
            wr_done_q   <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            len_l_q     <= len_l_d;
            stride_q    <= stride_d;
            gap_q       <= gap_d;
            total_n_q   <= total_n_d;
            row_base_q  <= row_base_d;
            col_off_q   <= col_off_d;
            inner_cnt_q <= inner_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_q      <= addr_d;
            src_q       <= src_d;
            from_dma_q  <= from_dma_d;
            mc_q        <= mc_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_dnoc_itf_in_d_channel_rx.sv
// tb/tb_dnoc_itf_in_d_channel_rx.sv - directed bench for dnoc_itf_in_d_channel_rx.
module tb_dnoc_itf_in_d_channel_rx;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] out_flit;
    logic         out_last, out_valid, out_ready;
    logic [12:0]  mem_wr_addr;
    logic [255:0] mem_wr_data, core_rd_ret_data, dma_wr_ret_data;
    logic         mem_wr_valid, mem_wr_ready;
    logic         core_rd_ret_valid, core_rd_ret_last, core_rd_ret_ready;
    logic         dma_wr_ret_valid, dma_wr_ret_last, dma_wr_ret_ready;
    logic [3:0]   hdr_src_id;
    logic         hdr_from_dma;
    logic [11:0]  hdr_mc_scale;
    logic         wr_done;
    logic [1:0]   err;
    logic         err_clr;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    dnoc_itf_in_d_channel_rx #(.NODE_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready),
        .core_rd_ret_data(core_rd_ret_data), .core_rd_ret_valid(core_rd_ret_valid),
        .core_rd_ret_last(core_rd_ret_last), .core_rd_ret_ready(core_rd_ret_ready),
        .dma_wr_ret_data(dma_wr_ret_data), .dma_wr_ret_valid(dma_wr_ret_valid),
        .dma_wr_ret_last(dma_wr_ret_last), .dma_wr_ret_ready(dma_wr_ret_ready),
        .hdr_src_id(hdr_src_id), .hdr_from_dma(hdr_from_dma), .hdr_mc_scale(hdr_mc_scale),
        .wr_done(wr_done), .err(err), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs are then driven and outputs sampled off-edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [255:0] f, input logic l, input logic v);
        out_flit  = f;
        out_last  = l;
        out_valid = v;
        #1;
    endtask

    function automatic logic [255:0] head(input logic typ, input logic sel, input logic [11:0] tgt,
                                          input logic [12:0] base, input logic [12:0] n,
                                          input logic [12:0] l, input logic [12:0] s,
                                          input logic [12:0] g, input logic [3:0] src);
        logic [255:0] h;
        h = '0;
        h[159:147] = l;
        h[107:95]  = s;
        h[94:82]   = g;
        h[55:43]   = n;
        h[30:18]   = base;
        h[17:14]   = src;
        h[13]      = sel;
        h[12]      = typ;
        h[11:0]    = tgt;
        return h;
    endfunction

    function automatic logic [255:0] dat(input int i);
        return {8{32'hA5000000 + 32'(i)}};
    endfunction

    initial begin
        logic [12:0] exp_addr [4];
        logic        len_err_exp;
`ifdef DNOC_RX_LEN_CHECK_EN
        len_err_exp = 1'b1;
`else
        len_err_exp = 1'b0;
`endif
        rst = 1'b1; err_clr = 1'b0;
        mem_wr_ready = 1'b1; core_rd_ret_ready = 1'b1; dma_wr_ret_ready = 1'b1;
        drive('0, 1'b0, 1'b0);
        cyc(); cyc();
        chk("rst_ready", out_ready, 1'b1);
        chk("rst_valids", {mem_wr_valid, core_rd_ret_valid, dma_wr_ret_valid}, 3'b000);
        chk("rst_lasts", {core_rd_ret_last, dma_wr_ret_last}, 2'b00);
        chk("rst_done_err", {wr_done, err}, 3'b000);
        chk("rst_hdr", {hdr_src_id, hdr_from_dma, hdr_mc_scale}, 17'h0);
        chk("rst_addr", mem_wr_addr, 13'h0);
        rst = 1'b0;

        // Stride-1 write
        drive(head(1'b0, 1'b0, 12'h000, 13'h100, 13'd4, 13'd4, 13'd1, 13'd0, 4'd3), 1'b0, 1'b1);
        chk("w1_head_ready", out_ready, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(dat(i), i == 3, 1'b1);
            chk($sformatf("w1_addr%0d", i), mem_wr_addr, 13'h100 + 13'(i));
            chk($sformatf("w1_valid%0d", i), mem_wr_valid, 1'b1);
            chk($sformatf("w1_data%0d", i), mem_wr_data, dat(i));
            chk($sformatf("w1_nodone%0d", i), wr_done, 1'b0);
            cyc();
        end
        drive('0, 1'b0, 1'b0);
        chk("w1_done", wr_done, 1'b1);
        chk("w1_err", err, 2'b00);
        chk("w1_idle", {out_ready, mem_wr_valid}, 2'b10);
        cyc();
        chk("w1_done_pulse", wr_done, 1'b0);

        // 2-D write with a one-cycle SRAM stall on beat 2
        exp_addr = '{13'h10, 13'h11, 13'h30, 13'h31};
        drive(head(1'b0, 1'b0, 12'h000, 13'h10, 13'd4, 13'd2, 13'd1, 13'h20, 4'd3), 1'b0, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(dat(10 + i), i == 3, 1'b1);
            if (i == 1) begin
                mem_wr_ready = 1'b0;
                #1;
                chk("w2_stall_ready", out_ready, 1'b0);
                cyc();
                chk("w2_stall_addr", mem_wr_addr, 13'h11);
                mem_wr_ready = 1'b1;
                #1;
            end
            chk($sformatf("w2_addr%0d", i), mem_wr_addr, exp_addr[i]);
            cyc();
        end
        drive('0, 1'b0, 1'b0);
        chk("w2_done", wr_done, 1'b1);

        // Core return, ready 1,0,1
        drive(head(1'b1, 1'b0, 12'hABC, 13'h0, 13'd3, 13'd0, 13'd0, 13'd0, 4'd5), 1'b0, 1'b1);
        cyc();
        chk("rc_mc_scale", hdr_mc_scale, 12'hABC);
        chk("rc_src_dma", {hdr_src_id, hdr_from_dma}, {4'd5, 1'b0});
        for (int i = 0; i < 3; i++) begin
            drive(dat(20 + i), i == 2, 1'b1);
            if (i == 1) begin
                core_rd_ret_ready = 1'b0;
                #1;
                chk("rc_stall", {out_ready, core_rd_ret_valid}, 2'b01);
                cyc();
                core_rd_ret_ready = 1'b1;
                #1;
            end
            chk($sformatf("rc_data%0d", i), core_rd_ret_data, dat(20 + i));
            chk($sformatf("rc_vl%0d", i), {core_rd_ret_valid, core_rd_ret_last, dma_wr_ret_valid, mem_wr_valid},
                {1'b1, i == 2, 2'b00});
            cyc();
        end
        drive('0, 1'b0, 1'b0);
        chk("rc_idle", {out_ready, core_rd_ret_valid, wr_done}, 3'b100);

        // DMA return, single flit
        drive(head(1'b1, 1'b1, 12'h123, 13'h0, 13'd1, 13'd0, 13'd0, 13'd0, 4'd9), 1'b0, 1'b1);
        cyc();
        drive(dat(30), 1'b1, 1'b1);
        chk("rd_vl", {dma_wr_ret_valid, dma_wr_ret_last, core_rd_ret_valid}, 3'b110);
        chk("rd_hdr", {hdr_src_id, hdr_from_dma, hdr_mc_scale}, {4'd9, 1'b1, 12'h123});
        cyc();
        drive('0, 1'b0, 1'b0);
        chk("rd_idle", {out_ready, dma_wr_ret_valid}, 2'b10);

        // Target mismatch drains
        drive(head(1'b0, 1'b0, 12'h001, 13'h40, 13'd2, 13'd0, 13'd1, 13'd0, 4'd1), 1'b0, 1'b1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            mem_wr_ready = 1'b0;
            drive(dat(40 + i), i == 1, 1'b1);
            chk($sformatf("tm_drain%0d", i), {out_ready, mem_wr_valid}, 2'b10);
            cyc();
        end
        mem_wr_ready = 1'b1;
        drive('0, 1'b0, 1'b0);
        chk("tm_err", err, 2'b10);
        chk("tm_no_done", wr_done, 1'b0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("tm_clr", err, 2'b00);

        // Length mismatch: N=3, last on flit 2
        drive(head(1'b0, 1'b0, 12'h000, 13'h200, 13'd3, 13'd0, 13'd1, 13'd0, 4'd1), 1'b0, 1'b1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(dat(50 + i), i == 1, 1'b1);
            cyc();
        end
        drive('0, 1'b0, 1'b0);
        chk("lm_err", err, {1'b0, len_err_exp});
        chk("lm_idle", {out_ready, wr_done}, 2'b11);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;

        // Reset mid-write
        drive(head(1'b0, 1'b0, 12'h000, 13'h300, 13'd4, 13'd0, 13'd1, 13'd0, 4'd1), 1'b0, 1'b1);
        cyc();
        drive(dat(60), 1'b0, 1'b1);
        cyc();
        rst = 1'b1;
        drive(dat(61), 1'b0, 1'b1);
        cyc();
        rst = 1'b0;
        out_valid = 1'b0;
        #1;
        chk("rm_idle", {out_ready, mem_wr_valid, core_rd_ret_valid, dma_wr_ret_valid}, 4'b1000);
        chk("rm_addr", mem_wr_addr, 13'h0);

        // Address wrap at the top of the 13-bit space
        drive(head(1'b0, 1'b0, 12'h000, 13'h1FFF, 13'd2, 13'd0, 13'd1, 13'd0, 4'd1), 1'b0, 1'b1);
        cyc();
        drive(dat(70), 1'b0, 1'b1);
        chk("wrap_addr0", mem_wr_addr, 13'h1FFF);
        cyc();
        drive(dat(71), 1'b1, 1'b1);
        chk("wrap_addr1", mem_wr_addr, 13'h0000);
        cyc();
        drive('0, 1'b0, 1'b0);
        chk("wrap_done_err", {wr_done, err}, 3'b100);

        // Header-only write
        drive(head(1'b0, 1'b0, 12'h000, 13'h5, 13'd0, 13'd0, 13'd0, 13'd0, 4'd2), 1'b1, 1'b1);
        cyc();
        drive('0, 1'b0, 1'b0);
        chk("ho_done", {wr_done, out_ready, mem_wr_valid}, 3'b110);
        cyc();
        chk("ho_pulse", wr_done, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/dnoc_itf_in_d_channel_rx.md
# dnoc_itf_in_d_channel_rx

Receive-side data-NoC interface for one node. It accepts packets ejected by the local router: one head flit followed by data flits, with `last` on the final flit. It decodes the head and then steers the payload to one of three sinks: the local SRAM write port (with address generation), the core read-return stream, or the DMA write-return stream. It is the counterpart of the node's NoC output channel, which builds and sends these head flits.

## Interface
- `NODE_ID`, default 4'd0: this node's ID, compared against bits [3:0] of write-packet heads.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `out_flit` in 256: flit from the router.
- `out_last` in 1: marks the final flit of a packet.
- `out_valid` in 1: flit valid.
- `out_ready` out 1: flit accepted when `out_valid & out_ready`.
- `mem_wr_addr` out 13: local SRAM write address.
- `mem_wr_data` out 256: SRAM write data.
- `mem_wr_valid` out 1: SRAM write valid.
- `mem_wr_ready` in 1: SRAM write ready.
- `core_rd_ret_data` out 256, `core_rd_ret_valid` out 1, `core_rd_ret_last` out 1, `core_rd_ret_ready` in 1: read-return stream to the core.
- `dma_wr_ret_data` out 256, `dma_wr_ret_valid` out 1, `dma_wr_ret_last` out 1, `dma_wr_ret_ready` in 1: read-return stream to the DMA.
- `hdr_src_id` out 4: latched head bits [17:14].
- `hdr_from_dma` out 1: latched head bit [13].
- `hdr_mc_scale` out 12: latched head bits [11:0].
- `wr_done` out 1: one-cycle pulse at the end of each write packet.
- `err` out 2: sticky error flags; [0] length mismatch, [1] target mismatch.
- `err_clr` in 1: clears `err`.

## Operation
- **Head fields:**
  - [255] multicast (ignored)
  - [159:147] inner loop length L
  - [107:95] inner stride S
  - [94:82] outer gap G
  - [55:43] total length N (flits)
  - [42:18] base address; bits [12:0] are used
  - [17:14] source ID
  - [13] origin for writes, or return select for returns (0 = core, 1 = DMA)
  - [12] type: 0 = write, 1 = read-return
  - [11:0] target ID or mc scale
- **States:** IDLE, WR, DRAIN, RET_CORE, RET_DMA.
- **IDLE**
  - `out_ready` = 1.
  - An accepted flit is a head; latch all fields.
  - Next state:
    - [12]=1 and [13]=0 → RET_CORE.
    - [12]=1 and [13]=1 → RET_DMA.
    - [12]=0 and [3:0]==NODE_ID → WR.
    - [12]=0 and [3:0]!=NODE_ID → DRAIN, set `err[1]`.
  - A head with `out_last`=1 is a header-only packet: stay in IDLE. If it is a write, pulse `wr_done`.
- **WR**
  - `mem_wr_valid` = `out_valid`; `mem_wr_data` = `out_flit`; `out_ready` = `mem_wr_ready`.
  - `mem_wr_addr` = row_base + col_off. At head accept: row_base = base[12:0], col_off = 0, inner_cnt = 0.
  - Per accepted beat:
    - If L != 0 and inner_cnt == L-1: row_base += G, col_off = 0, inner_cnt = 0.
    - Otherwise: col_off += S, inner_cnt++.
  - All address arithmetic is mod 2^13 (wraps).
  - L = 0 means no outer wrap.
  - On the last beat: pulse `wr_done` next cycle, return to IDLE.
- **DRAIN:** `out_ready` = 1; flits are discarded; return to IDLE on the last flit.
- **RET_CORE / RET_DMA:**
  - Pass-through to the selected stream: data, valid and last from the flit; `out_ready` = that stream's ready.
  - Return to IDLE on the accepted last flit.
  - The stream that is not selected keeps valid = 0.
- **Flit count:** beat_cnt counts accepted data flits in every state.
- **`err_clr`:** clears `err`. If an error sets in the same cycle, the set wins.

## Timing
- **Reset (synchronous):**
  - State = IDLE.
  - `mem_wr_valid`, `core_rd_ret_valid`, `dma_wr_ret_valid`, all `last` outputs, `wr_done` and `err` = 0.
  - `hdr_*` = 0; counters = 0.
  - `out_ready` = 1 (IDLE).
- **Reset mid-packet:** the partial packet is abandoned. The router side must be reset together with this block; otherwise trailing flits are decoded as heads.
- **Head cost:** one cycle in IDLE. The first data flit can be accepted on the following cycle.
- **Data path:** combinational, zero latency, no bubbles; one beat per cycle at full throughput.
- **Address update:** `mem_wr_addr` is registered and updates on the clock edge after each accepted beat.
- **Simultaneous last and head:** impossible; a new head is only accepted in IDLE.
- **`wr_done`:** asserted exactly one cycle, in the cycle after the last write beat (or after a header-only write head).
- **Backpressure:** with sink ready low, the flit is held by the router; outputs follow `out_flit` combinationally.

## Configuration
- **`DNOC_RX_LEN_CHECK_EN` defined:** on the accepted last flit, if beat_cnt+1 != N, set `err[0]`. Applies to WR and DRAIN only.
- **Undefined:** `err[0]` is tied to 0; `out_last` alone terminates the packet. No other behavioural change.

## Test plan
- **Stride-1 write:** write head with base=0x100, N=4, L=4, S=1, G=0 → `mem_wr_addr` 0x100–0x103, `wr_done` one cycle after beat 4, `err`=0.
- **2-D write:** L=2, S=1, G=0x20, N=4, base=0x10 → addresses 0x10, 0x11, 0x30, 0x31.
- **Core return with backpressure:** head [12]=1, [13]=0, 3 data flits, `core_rd_ret_ready` toggling 1,0,1 → three beats delivered in order, `core_rd_ret_last` on beat 3, `dma_wr_ret_valid` stays 0, `hdr_mc_scale` equals head [11:0].
- **Target mismatch:** write head with [3:0] = NODE_ID+1, 2 data flits → no `mem_wr_valid`, `err[1]`=1; `err_clr` clears it.
- **Length mismatch (macro on):** N=3 but `last` on flit 2 → `err[0]`=1, return to IDLE. With the macro off → `err[0]`=0.
- **Reset / wrap:** `rst` asserted mid-WR → next cycle IDLE with all valids 0. Separately, base=0x1FFF, N=2, S=1 → addresses 0x1FFF, 0x0000.
